// File: rtl/layer_param_loader.sv
// Streams one layer's weights then biases from a 32-bit valid/ready interface into
// packed storage buses laid out for the matrix-multiply and bias-add stages.
module layer_param_loader #(
    parameter int unsigned MAXWEIGHTS = 4,
    parameter int unsigned MAXNEURONS = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [31:0]                          layer_neurons,
    input  logic [31:0]                          layer_inputs,
    input  logic                                 in_valid,
    input  logic [31:0]                          in_data,
    output logic                                 in_ready,
    output logic [32*MAXWEIGHTS*MAXNEURONS-1:0]  weightstorage,
    output logic [32*MAXNEURONS-1:0]             biasstorage,
    output logic [31:0]                          neuron_cnt,
    output logic [31:0]                          input_cnt,
    output logic                                 busy,
    output logic                                 load_done,
    output logic                                 cfg_error
);

    localparam int unsigned NumSlots = MAXWEIGHTS * MAXNEURONS;

    typedef enum logic [1:0] {StIdle, StLoadW, StLoadB, StDone} state_e;

    state_e      state_q;
    logic [31:0] weight_q [NumSlots];
    logic [31:0] bias_q [MAXNEURONS];
    logic [31:0] neuron_cnt_q, input_cnt_q;
    logic [31:0] n_q, k_q;
    logic        in_ready_q, busy_q, load_done_q, cfg_error_q;

    logic        cfg_ok;
    logic        last_k, last_n;
    logic [31:0] w_slot;

    assign cfg_ok = (layer_neurons != '0) && (layer_neurons <= MAXNEURONS) &&
                    (layer_inputs != '0) && (layer_inputs <= MAXWEIGHTS);
    assign last_k = (k_q == input_cnt_q - 32'd1);
    assign last_n = (n_q == neuron_cnt_q - 32'd1);
    // Rows are strided by MAXWEIGHTS so the multiplier sees a fixed layout.
    assign w_slot = n_q * MAXWEIGHTS + k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            neuron_cnt_q <= '0;
            input_cnt_q  <= '0;
            n_q          <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            cfg_error_q  <= 1'b0;
            for (int unsigned s = 0; s < NumSlots; s++) weight_q[s] <= '0;
            for (int unsigned s = 0; s < MAXNEURONS; s++) bias_q[s] <= '0;
        end else begin
            load_done_q <= 1'b0;
            cfg_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_ok) begin
                            neuron_cnt_q <= layer_neurons;
                            input_cnt_q  <= layer_inputs;
                            n_q          <= '0;
                            k_q          <= '0;
                            in_ready_q   <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= StLoadW;
                            for (int unsigned s = 0; s < NumSlots; s++) weight_q[s] <= '0;
                            for (int unsigned s = 0; s < MAXNEURONS; s++) bias_q[s] <= '0;
                        end else begin
                            cfg_error_q <= 1'b1;
                        end
                    end
                end
                StLoadW: begin
                    if (in_valid) begin
                        for (int unsigned s = 0; s < NumSlots; s++) begin
                            if (w_slot == s) weight_q[s] <= in_data;
                        end
                        if (last_k) begin
                            k_q <= '0;
                            if (last_n) begin
                                n_q     <= '0;
                                state_q <= StLoadB;
                            end else begin
                                n_q <= n_q + 32'd1;
                            end
                        end else begin
                            k_q <= k_q + 32'd1;
                        end
                    end
                end
                StLoadB: begin
                    if (in_valid) begin
                        for (int unsigned s = 0; s < MAXNEURONS; s++) begin
                            if (n_q == s) bias_q[s] <= in_data;
                        end
                        if (last_n) begin
                            n_q         <= '0;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            load_done_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            n_q <= n_q + 32'd1;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar s = 0; s < NumSlots; s++) begin : g_wpack
        assign weightstorage[32*s +: 32] = weight_q[s];
    end
    for (genvar s = 0; s < MAXNEURONS; s++) begin : g_bpack
        assign biasstorage[32*s +: 32] = bias_q[s];
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign cfg_error  = cfg_error_q;
    assign neuron_cnt = neuron_cnt_q;
    assign input_cnt  = input_cnt_q;

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed bench for layer_param_loader: one task per scenario, inline comparisons
// against hand-computed storage images.
module tb_layer_param_loader;

    localparam int MW = 4;
    localparam int MN = 10;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [31:0]       layer_neurons, layer_inputs, in_data;
    logic              in_ready, busy, load_done, cfg_error;
    logic [32*MW*MN-1:0] weightstorage;
    logic [32*MN-1:0]  biasstorage;
    logic [31:0]       neuron_cnt, input_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_w [MW*MN];
    logic [31:0] exp_b [MN];

    layer_param_loader #(.MAXWEIGHTS(MW), .MAXNEURONS(MN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .layer_neurons(layer_neurons), .layer_inputs(layer_inputs),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .weightstorage(weightstorage), .biasstorage(biasstorage),
        .neuron_cnt(neuron_cnt), .input_cnt(input_cnt),
        .busy(busy), .load_done(load_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] nn, input logic [31:0] ni);
        start = 1'b1; layer_neurons = nn; layer_inputs = ni;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_exp();
        for (int s = 0; s < MW*MN; s++) exp_w[s] = '0;
        for (int s = 0; s < MN; s++) exp_b[s] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        layer_neurons = 32'd1; layer_inputs = 32'd1;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, load_done, cfg_error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {in_ready, busy, load_done, cfg_error});
        end
        checks++;
        if (neuron_cnt !== 32'd0 || input_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", neuron_cnt, input_cnt);
        end
        checks++;
        if (weightstorage !== '0 || biasstorage !== '0) begin
            errors++;
            $display("FAIL reset_storage got nonzero want 0");
        end
    endtask

    task automatic test_full_layer();
        int done_at = -1;
        clear_exp();
        for (int i = 0; i < 40; i++) exp_w[i] = 32'h3F80_0000 + i;
        for (int j = 0; j < 10; j++) exp_b[j] = 32'h4000_0000 + j;
        do_start(32'd10, 32'd4);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_enter got ready=%b busy=%b want 1 1", in_ready, busy);
        end
        // Edge e presents word e-1; the DONE cycle is the 51st cycle after the start edge.
        for (int e = 1; e <= 50; e++) begin
            in_valid = 1'b1;
            in_data = (e <= 40) ? exp_w[e-1] : exp_b[e-41];
            tick();
            if (load_done === 1'b1 && done_at < 0) done_at = e;
        end
        in_valid = 1'b0;
        checks++;
        if (done_at != 50) begin
            errors++;
            $display("FAIL full_done_latency got edge %0d want edge 50", done_at);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_after got done=%b busy=%b ready=%b want 0 0 0",
                     load_done, busy, in_ready);
        end
        checks++;
        if (neuron_cnt !== 32'd10 || input_cnt !== 32'd4) begin
            errors++;
            $display("FAIL full_counts got %0d/%0d want 10/4", neuron_cnt, input_cnt);
        end
        for (int s = 0; s < MW*MN; s++) begin
            checks++;
            if (weightstorage[32*s +: 32] !== exp_w[s]) begin
                errors++;
                $display("FAIL full_w[%0d] got %h want %h", s, weightstorage[32*s +: 32], exp_w[s]);
            end
        end
        for (int s = 0; s < MN; s++) begin
            checks++;
            if (biasstorage[32*s +: 32] !== exp_b[s]) begin
                errors++;
                $display("FAIL full_b[%0d] got %h want %h", s, biasstorage[32*s +: 32], exp_b[s]);
            end
        end
    endtask

    task automatic test_partial_stride();
        logic [31:0] w [6];
        for (int i = 0; i < 6; i++) w[i] = 32'hA000_0000 + i;
        clear_exp();
        exp_w[0] = w[0]; exp_w[1] = w[1]; exp_w[4] = w[2];
        exp_w[5] = w[3]; exp_w[8] = w[4]; exp_w[9] = w[5];
        for (int j = 0; j < 3; j++) exp_b[j] = 32'hB000_0000 + j;
        do_start(32'd3, 32'd2);
        for (int i = 0; i < 6; i++) send(w[i]);
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL stride_early_done got 1 want 0");
        end
        for (int j = 0; j < 3; j++) send(exp_b[j]);
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL stride_done got %b want 1", load_done);
        end
        tick();
        for (int s = 0; s < MW*MN; s++) begin
            checks++;
            if (weightstorage[32*s +: 32] !== exp_w[s]) begin
                errors++;
                $display("FAIL stride_w[%0d] got %h want %h", s, weightstorage[32*s +: 32], exp_w[s]);
            end
        end
        for (int s = 0; s < MN; s++) begin
            checks++;
            if (biasstorage[32*s +: 32] !== exp_b[s]) begin
                errors++;
                $display("FAIL stride_b[%0d] got %h want %h", s, biasstorage[32*s +: 32], exp_b[s]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int done_at = -1;
        int accepted = 0;
        logic [31:0] v [6];
        for (int i = 0; i < 6; i++) v[i] = 32'hC000_0000 + i;
        clear_exp();
        exp_w[0] = v[0]; exp_w[1] = v[1]; exp_w[4] = v[2]; exp_w[5] = v[3];
        exp_b[0] = v[4]; exp_b[1] = v[5];
        do_start(32'd2, 32'd2);
        // Valid on edges 1,4,7,...; junk data rides on the idle cycles.
        for (int e = 1; e <= 18; e++) begin
            if ((e % 3) == 1 && accepted < 6) begin
                in_valid = 1'b1; in_data = v[accepted]; accepted++;
            end else begin
                in_valid = 1'b0; in_data = 32'hDEAD_0000 + e;
            end
            tick();
            if (load_done === 1'b1 && done_at < 0) done_at = e;
        end
        in_valid = 1'b0;
        checks++;
        if (done_at != 16) begin
            errors++;
            $display("FAIL gaps_done_edge got %0d want 16", done_at);
        end
        for (int s = 0; s < MW*MN; s++) begin
            checks++;
            if (weightstorage[32*s +: 32] !== exp_w[s]) begin
                errors++;
                $display("FAIL gaps_w[%0d] got %h want %h", s, weightstorage[32*s +: 32], exp_w[s]);
            end
        end
        for (int s = 0; s < MN; s++) begin
            checks++;
            if (biasstorage[32*s +: 32] !== exp_b[s]) begin
                errors++;
                $display("FAIL gaps_b[%0d] got %h want %h", s, biasstorage[32*s +: 32], exp_b[s]);
            end
        end
    endtask

    task automatic test_cfg_errors();
        logic [31:0] bad_n [3];
        logic [31:0] bad_i [3];
        bad_n[0] = 32'd0;  bad_i[0] = 32'd2;
        bad_n[1] = 32'd11; bad_i[1] = 32'd2;
        bad_n[2] = 32'd2;  bad_i[2] = 32'd5;
        for (int t = 0; t < 3; t++) begin
            do_start(bad_n[t], bad_i[t]);
            checks++;
            if (cfg_error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err%0d got err=%b ready=%b busy=%b want 1 0 0",
                         t, cfg_error, in_ready, busy);
            end
            tick();
            checks++;
            if (cfg_error !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL cfg_pulse%0d got err=%b ready=%b want 0 0", t, cfg_error, in_ready);
            end
        end
        checks++;
        if (neuron_cnt !== 32'd2 || input_cnt !== 32'd2) begin
            errors++;
            $display("FAIL cfg_counts got %0d/%0d want 2/2", neuron_cnt, input_cnt);
        end
        for (int s = 0; s < MW*MN; s++) begin
            checks++;
            if (weightstorage[32*s +: 32] !== exp_w[s]) begin
                errors++;
                $display("FAIL cfg_w[%0d] got %h want %h", s, weightstorage[32*s +: 32], exp_w[s]);
            end
        end
        for (int s = 0; s < MN; s++) begin
            checks++;
            if (biasstorage[32*s +: 32] !== exp_b[s]) begin
                errors++;
                $display("FAIL cfg_b[%0d] got %h want %h", s, biasstorage[32*s +: 32], exp_b[s]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int seen_done = 0;
        do_start(32'd2, 32'd3);
        for (int i = 0; i < 5; i++) send(32'hD000_0000 + i);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (weightstorage !== '0 || biasstorage !== '0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got ready=%b busy=%b storage_zero=%b want 0 0 1",
                     in_ready, busy, (weightstorage == '0 && biasstorage == '0));
        end
        for (int e = 0; e < 6; e++) begin
            in_valid = 1'b1; in_data = 32'hD100_0000 + e;
            tick();
            if (load_done === 1'b1 || in_ready === 1'b1) seen_done++;
        end
        in_valid = 1'b0;
        checks++;
        if (seen_done != 0 || weightstorage !== '0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", seen_done);
        end
        do_start(32'd1, 32'd1);
        send(32'h1234_5678);
        send(32'h8765_4321);
        checks++;
        if (load_done !== 1'b1 || weightstorage[31:0] !== 32'h1234_5678 ||
            biasstorage[31:0] !== 32'h8765_4321) begin
            errors++;
            $display("FAIL midrst_reload got done=%b w0=%h b0=%h want 1 12345678 87654321",
                     load_done, weightstorage[31:0], biasstorage[31:0]);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        do_start(32'd2, 32'd2);
        send(32'hE000_0000);
        start = 1'b1; layer_neurons = 32'd5; layer_inputs = 32'd3;
        send(32'hE000_0001);
        start = 1'b0;
        checks++;
        if (neuron_cnt !== 32'd2 || input_cnt !== 32'd2 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got %0d/%0d err=%b want 2/2 0",
                     neuron_cnt, input_cnt, cfg_error);
        end
        for (int i = 2; i < 6; i++) send(32'hE000_0000 + i);
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_done got %b want 1", load_done);
        end
        checks++;
        if (weightstorage[5*32 +: 32] !== 32'hE000_0003 || biasstorage[32 +: 32] !== 32'hE000_0005) begin
            errors++;
            $display("FAIL busy_data got w5=%h b1=%h want e0000003 e0000005",
                     weightstorage[5*32 +: 32], biasstorage[32 +: 32]);
        end
        // Start presented during the DONE cycle must be dropped.
        do_start(32'd1, 32'd1);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || neuron_cnt !== 32'd2) begin
            errors++;
            $display("FAIL done_start got ready=%b busy=%b n=%0d want 0 0 2",
                     in_ready, busy, neuron_cnt);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || weightstorage[5*32 +: 32] !== 32'hE000_0003) begin
            errors++;
            $display("FAIL done_start_idle got ready=%b w5=%h want 0 e0000003",
                     in_ready, weightstorage[5*32 +: 32]);
        end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_partial_stride();
        test_back_pressure();
        test_cfg_errors();
        test_reset_mid_load();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_param_loader.md
Name: layer_param_loader

Overview:
- Writer side of the per-layer weight/bias storage consumed by the neural network datapath (matrix multiply -> bias add -> activation).
- Replaces file-based per-layer loading with a streamed 32-bit word interface.
- Accepts a layer descriptor, then a valid/ready stream: all weights first, then all biases.
- Drives packed weight and bias buses laid out exactly as the matrix-multiply and vector-add stages consume them, and pulses `load_done` when the layer is complete.

Parameters:
- MAXWEIGHTS, 4, max inputs per neuron (row stride of weight storage)
- MAXNEURONS, 10, max neurons per layer

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin loading a layer
- layer_neurons  input  32  neuron count of the layer, sampled on accepted start
- layer_inputs  input  32  inputs per neuron, sampled on accepted start
- in_valid  input  1  stream word valid
- in_data  input  32  stream word: IEEE-754 single, passed through unmodified
- in_ready  output  1  loader can accept a stream word
- weightstorage  output  32*MAXWEIGHTS*MAXNEURONS  packed weights; slot n*MAXWEIGHTS+k at bits [32*slot +: 32]
- biasstorage  output  32*MAXNEURONS  packed biases; slot n at bits [32*n +: 32]
- neuron_cnt  output  32  latched layer_neurons, for the datapath l input
- input_cnt  output  32  latched layer_inputs, for the datapath m input
- busy  output  1  high in LOAD_W and LOAD_B
- load_done  output  1  one-cycle pulse when the layer is fully loaded
- cfg_error  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values: all storage 0, neuron_cnt = 0, input_cnt = 0, in_ready = 0, busy = 0, load_done = 0, cfg_error = 0, state IDLE.
- Reset during loading aborts the load, clears the storage, and returns to IDLE with no load_done.
- States: IDLE, LOAD_W, LOAD_B, DONE.
- IDLE, start = 1, config valid:
  - Config valid means 1 <= layer_neurons <= MAXNEURONS and 1 <= layer_inputs <= MAXWEIGHTS.
  - Latch neuron_cnt and input_cnt.
  - Zero all weight and bias slots in the same edge, so unused slots read 0.
  - Set n = 0, k = 0 and go to LOAD_W.
- IDLE, start = 1, config invalid: pulse cfg_error next cycle, stay in IDLE, storage and counts unchanged.
- start outside IDLE is ignored: no error, no effect.
- Handshake:
  - in_ready = 1 exactly in LOAD_W and LOAD_B; it is a registered state decode, not dependent on in_valid.
  - A word is accepted on an edge with in_valid & in_ready.
  - in_data and in_valid outside these states are ignored.
- LOAD_W:
  - Accepted word is written to weight slot n*MAXWEIGHTS+k.
  - k increments; when k == input_cnt-1, k wraps to 0 and n increments.
  - After the last weight (n == neuron_cnt-1, k == input_cnt-1), reset n to 0 and go to LOAD_B.
  - Total weights = neuron_cnt*input_cnt, row-major by neuron.
- LOAD_B:
  - Accepted word is written to bias slot n, then n increments.
  - After n == neuron_cnt-1, go to DONE.
- DONE: load_done = 1 for exactly this cycle, then IDLE. A start in the DONE cycle is ignored.
- Storage holds its contents in IDLE until the next accepted start or reset.
- Gaps: in_valid may drop for any number of cycles; counters hold.
- Minimum load latency: start edge + neuron_cnt*(input_cnt+1) word cycles + 1 DONE cycle.
- No arithmetic on data; counters are 32-bit but bounded by the parameters.

Test Plan:
- Single full-size layer:
  - Stimulus: rst, then start with neurons = 10, inputs = 4; stream 40 weights 0x3F800000+i, then 10 biases 0x40000000+j, in_valid held high.
  - Required: weight slot i = 0x3F800000+i; bias slot j = 0x40000000+j; load_done pulses exactly 51 cycles after the start edge; busy low after.
- Partial layer with stride:
  - Stimulus: neurons = 3, inputs = 2; weights w0..w5.
  - Required: w0..w5 land in slots 0, 1, 4, 5, 8, 9; all other weight slots = 0; bias slots 3..9 = 0.
- Back-pressure gaps:
  - Stimulus: neurons = 2, inputs = 2; in_valid toggles 1,0,0,1,...
  - Required: only valid words are stored, in order; load_done follows the 6th accepted word by one cycle.
- Config errors:
  - Stimulus: start with neurons = 0; start with neurons = 11; start with inputs = 5.
  - Required: each gives a one-cycle cfg_error, state stays IDLE, in_ready = 0, prior storage preserved.
- Reset mid-load:
  - Stimulus: rst after 5 of 8 words.
  - Required: all storage = 0, in_ready = 0, no load_done. A fresh start then loads correctly.
- Start while busy:
  - Stimulus: second start during LOAD_W with different sizes.
  - Required: ignored; neuron_cnt and input_cnt keep the first values and the load completes normally.
